// File: rtl/down_counter_timer.sv
// Programmable down-counter/timer with one-shot or auto-reload modes,
// a one-cycle terminal-count pulse and a combinational borrow for cascading.
module down_counter_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             borrow_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_nx;
    logic [WIDTH-1:0] q_nx;
    logic             tc_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            q          <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_nx;
            q          <= q_nx;
            reload_reg <= reload_nx;
            tc         <= tc_nx;
        end
    end

    // Priority: load, then start, then counting; tc is only raised on a consumed zero.
    always_comb begin
        state_nx  = state;
        q_nx      = q;
        reload_nx = reload_reg;
        tc_nx     = 1'b0;
        if (load) begin
            q_nx      = load_val;
            reload_nx = load_val;
            state_nx  = IDLE;
        end else if (start) begin
            q_nx     = reload_reg;
            state_nx = RUN;
        end else if (state == RUN && en) begin
            if (q == '0) begin
                tc_nx = 1'b1;
                if (mode) begin
                    q_nx = reload_reg;
                end else begin
                    state_nx = DONE;
                end
            end else begin
                q_nx = q - WIDTH'(1);
            end
        end
    end

    assign busy       = (state == RUN);
    assign borrow_out = en && (state == RUN) && (q == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed vector table, hand-written
// reset/long-count sequences, and randomized stimulus against a reference model.
module tb_down_counter_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       en;
    logic       mode;
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       borrow_out;

    int n_vec;
    int n_err;

    down_counter_timer #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .en         (en),
        .mode       (mode),
        .q          (q),
        .tc         (tc),
        .busy       (busy),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       st;
        logic       e;
        logic       m;
        logic [3:0] eq;
        logic       etc;
        logic       ebusy;
        logic       eborrow;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ld, input logic [3:0] lv, input logic st,
                                input logic e, input logic m, input logic [3:0] eq,
                                input logic etc, input logic ebusy, input logic eborrow);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.e = e; v.m = m;
        v.eq = eq; v.etc = etc; v.ebusy = ebusy; v.eborrow = eborrow;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [3:0] lv, input logic st,
                         input logic e, input logic m);
        @(negedge clk);
        load = ld; load_val = lv; start = st; en = e; mode = m;
    endtask

    // Reference model: abstract count/reload values and a running flag.
    int mq, mr, mtc;
    bit mrun;

    task automatic model_step(input logic ld, input logic [3:0] lv, input logic st,
                              input logic e, input logic m);
        mtc = 0;
        if (ld) begin
            mq = lv; mr = lv; mrun = 0;
        end else if (st) begin
            mq = mr; mrun = 1;
        end else if (mrun && e) begin
            if (mq > 0) mq = mq - 1;
            else begin
                mtc = 1;
                if (m) mq = mr;
                else mrun = 0;
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b0; load = 0; load_val = 0; start = 0; en = 0; mode = 0;
        #23;
        chk("reset_q", q, 0);
        chk("reset_tc", tc, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b1;

        //           ld lv st en m  q  tc bz br
        tbl.push_back(mk(1, 3, 0, 0, 0, 3, 0, 0, 0));  // one-shot from 3
        tbl.push_back(mk(0, 0, 1, 1, 0, 3, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, 1, 1, 2, 0, 0, 0));  // auto-reload from 2
        tbl.push_back(mk(0, 0, 1, 1, 1, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 1, 0));  // enable gating
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 2, 0, 1, 0));  // restart while running
        tbl.push_back(mk(1, 7, 1, 1, 1, 7, 0, 0, 0));  // load beats start
        tbl.push_back(mk(0, 0, 1, 1, 1, 7, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 6, 0, 1, 0));
        tbl.push_back(mk(1, 9, 0, 1, 1, 9, 0, 0, 0));  // load aborts run
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0));  // reload of zero
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].e, tbl[i].m);
            #1 chk($sformatf("vec%0d_borrow", i), borrow_out, tbl[i].eborrow);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_q", i), q, tbl[i].eq);
            chk($sformatf("vec%0d_tc", i), tc, tbl[i].etc);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].ebusy);
        end

        // Asynchronous reset in the middle of a paused count at 9
        drive(1, 9, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        #1 chk("pre_reset_q", q, 9);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("async_reset_q", q, 0);
        chk("async_reset_tc", tc, 0);
        chk("async_reset_busy", busy, 0);
        #4 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 1, 1);
            @(posedge clk);
            #1;
            chk($sformatf("post_reset%0d_q", k), q, 0);
            chk($sformatf("post_reset%0d_busy", k), busy, 0);
        end
        drive(0, 0, 1, 1, 1);  // start after reset uses cleared reload register
        @(posedge clk);
        #1 chk("post_reset_start_q", q, 0);

        // Maximum load, one-shot: 16 enabled cycles after start, tc only on the last
        drive(1, 15, 0, 0, 0);
        drive(0, 0, 1, 1, 0);
        @(posedge clk);
        #1 chk("max_start_q", q, 15);
        for (int k = 1; k <= 16; k++) begin
            drive(0, 0, 0, 1, 0);
            @(posedge clk);
            #1;
            chk($sformatf("max%0d_tc", k), tc, (k == 16) ? 1 : 0);
            chk($sformatf("max%0d_q", k), q, (k < 16) ? 15 - k : 0);
        end
        chk("max_done_busy", busy, 0);

        // Randomized run against the reference model
        mq = 0; mr = 0; mrun = 0; mtc = 0;
        for (int i = 0; i < 500; i++) begin
            logic       rld, rst, ren, rmd;
            logic [3:0] rlv;
            rld = (i == 0) || ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 14) == 0);
            ren = ($urandom_range(0, 3) != 0);
            rmd = 1'($urandom);
            rlv = 4'($urandom);
            drive(rld, rlv, rst, ren, rmd);
            #1 chk($sformatf("rnd%0d_borrow", i), borrow_out, (ren && mrun && mq == 0) ? 1 : 0);
            model_step(rld, rlv, rst, ren, rmd);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_q", i), q, mq);
            chk($sformatf("rnd%0d_tc", i), tc, mtc);
            chk($sformatf("rnd%0d_busy", i), busy, mrun);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Programmable down-counter/timer: counts down from a loaded value and wraps or stops at zero, emitting a one-cycle terminal-count pulse. It is the counterpart of the free-running 4-bit up-counter and is used as a countdown/interval timer; it cascades via borrow_out. Synchronous to clk, with an asynchronous active-low reset.

Parameters:
WIDTH, 4, counter and load-value width in bits

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
load  input  1  load load_val into q and reload register
load_val  input  WIDTH  value to load
start  input  1  begin/restart countdown from reload register
en  input  1  count enable; counter holds when 0
mode  input  1  0 = one-shot (stop at zero), 1 = auto-reload (periodic)
q  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse (registered), 1 cycle
busy  output  1  1 while in RUN state (registered state decode)
borrow_out  output  1  combinational: en && state==RUN && q==0

Behaviour:
- Interface: reset reset, asynchronous, active-low; clock clk.
- Reset (reset==0, any time, including mid-count): q=0, reload_reg=0, state=IDLE, tc=0, busy=0 immediately, without waiting for clk. Counting resumes only after reset deasserts and start is seen.
- States: IDLE, RUN, DONE. busy=1 only in RUN.
- Priority per posedge: load > start > count.
- load=1 (any state): q<=load_val, reload_reg<=load_val, state<=IDLE, tc<=0. A load during RUN aborts the countdown.
- start=1 (load=0, any state): q<=reload_reg, state<=RUN, tc<=0. start during RUN restarts from reload_reg.
- RUN, en=1, q!=0: q<=q-1, tc<=0.
- RUN, en=1, q==0: tc<=1 for exactly that next cycle.
  - mode=1: q<=reload_reg, stay RUN.
  - mode=0: q stays 0, state<=DONE.
- RUN, en=0: q, state hold; tc<=0. Pauses do not generate tc.
- IDLE/DONE: q holds; en ignored; tc<=0.
- Period in auto-reload: reload_reg+1 enabled cycles per tc (e.g. load 3 → q 3,2,1,0,3,… with tc high in the cycle q shows 3 again).
- reload_reg==0 in mode=1: q stays 0, tc=1 every enabled cycle. In mode=0: one tc, then DONE.
- mode is sampled only at the q==0 decision. Changing it mid-count is legal.
- Arithmetic: unsigned WIDTH-bit. Decrement never underflows because the zero case is handled explicitly. Max load 2^WIDTH-1.
- borrow_out is combinational for cascading into a higher stage's en. It is asserted in the same cycle q==0 is being consumed.

Test Plan:
- Reset: hold reset=0 for 5ns mid-RUN with q=9 → q=0, tc=0, busy=0 asynchronously. After release with no start → q stays 0, IDLE.
- One-shot: load_val=3, load, start, mode=0, en=1 → q 3,2,1,0. Next cycle tc=1 for 1 cycle, q=0, busy=0 (DONE). Further en → no change.
- Auto-reload: load_val=2, mode=1, en=1 → q 2,1,0,2,1,0,2. tc high on each return to 2. borrow_out high while q==0.
- Enable gating/restart: mid-count q=5, en=0 for 3 cycles → q holds 5, tc=0. start during RUN → q=reload_reg next cycle.
- Priority: load=1 and start=1 together with load_val=7 → q=7, state IDLE, busy=0. Load during RUN q=4 → aborts, q=7.
- Edge values: load_val=0, mode=1 → tc=1 every enabled cycle. load_val=15, mode=0 → 16 counting cycles, then tc once.
